pixel_serializer: RTL

Downstream consumer of the colour lookup: takes one batch of NUM_ENGINES parallel RGB results (one per Mandelbrot engine, lane i = screen column x+i) and emits them one pixel per cycle on a valid/ready video stream, with start-of-frame and end-of-line markers. It sits between the colour LUT output and the frame-buffer / video DMA writer. It tracks screen position itself. The final batch of a line is truncated when SCREEN_WIDTH is not a multiple of NUM_ENGINES.

---
 rtl/mandelbrot_pkg.sv | 17 +
 rtl/pixel_pos_counter.sv | 53 +++++
 rtl/pixel_serializer.sv | 110 +++++++++++
 3 files changed

// File: rtl/mandelbrot_pkg.sv
// Shared constants and types for the Mandelbrot render pipeline.
// Screen geometry, engine count and pixel format used by the engines and the serializer.
package mandelbrot_pkg;

    localparam int RBG_SIZE      = 24;
    localparam int NUM_ENGINES   = 12;
    localparam int SCREEN_WIDTH  = 640;
    localparam int SCREEN_HEIGHT = 480;

    typedef logic [RBG_SIZE-1:0] rgb_t;

    typedef enum logic {
        EMPTY,
        SHIFT
    } ser_state_t;

endpackage

// File: rtl/pixel_pos_counter.sv
// Raster x/y position tracker; advances one pixel per asserted advance, wrapping per line and frame.
// Latency: position updates on the edge where advance is sampled; flags are combinational from the counters.
module pixel_pos_counter
    import mandelbrot_pkg::*;
#(
    parameter int WIDTH  = SCREEN_WIDTH,
    parameter int HEIGHT = SCREEN_HEIGHT,
    localparam int XW    = (WIDTH  > 1) ? $clog2(WIDTH)  : 1,
    localparam int YW    = (HEIGHT > 1) ? $clog2(HEIGHT) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          advance,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          at_sof,
    output logic          at_eol,
    output logic          at_eof
);

    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;

    assign x      = x_q;
    assign y      = y_q;
    assign at_sof = (x_q == '0) && (y_q == '0);
    assign at_eol = (x_q == XW'(WIDTH - 1));
    assign at_eof = at_eol && (y_q == YW'(HEIGHT - 1));

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (advance) begin
            if (at_eol) begin
                x_d = '0;
                y_d = at_eof ? '0 : y_q + YW'(1);
            end else begin
                x_d = x_q + XW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

endmodule

// File: rtl/pixel_serializer.sv
// Serializes a batch of NUM_ENGINES parallel colour results into a one-pixel-per-cycle video stream with SOF/EOL.
// Latency: batch accepted at edge N shows lane 0 in the following cycle; backpressure on out_ready holds all state.
module pixel_serializer
    import mandelbrot_pkg::ser_state_t, mandelbrot_pkg::EMPTY, mandelbrot_pkg::SHIFT;
#(
    parameter int RBG_SIZE      = mandelbrot_pkg::RBG_SIZE,
    parameter int NUM_ENGINES   = mandelbrot_pkg::NUM_ENGINES,
    parameter int SCREEN_WIDTH  = mandelbrot_pkg::SCREEN_WIDTH,
    parameter int SCREEN_HEIGHT = mandelbrot_pkg::SCREEN_HEIGHT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [RBG_SIZE-1:0] in_rgb [NUM_ENGINES],
    output logic                out_valid,
    input  logic                out_ready,
    output logic [RBG_SIZE-1:0] out_data,
    output logic                out_sof,
    output logic                out_eol,
    output logic                frame_done
);

    localparam int LW = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1;
    localparam int XW = (SCREEN_WIDTH > 1) ? $clog2(SCREEN_WIDTH) : 1;
    localparam int YW = (SCREEN_HEIGHT > 1) ? $clog2(SCREEN_HEIGHT) : 1;

    ser_state_t          state_q, state_d;
    logic [LW-1:0]       lane_q, lane_d;
    logic [LW-1:0]       last_lane_q, last_lane_d;
    logic                frame_done_q, frame_done_d;
    logic [RBG_SIZE-1:0] lane_buf_q [NUM_ENGINES];
    logic [RBG_SIZE-1:0] lane_buf_d [NUM_ENGINES];

    logic [XW-1:0]       pos_x;
    logic [YW-1:0]       pos_y;
    logic                at_sof, at_eol, at_eof;
    logic                out_hs, last_hs, in_acc;
    logic [XW-1:0]       x_start;
    int                  rem;

    pixel_pos_counter #(
        .WIDTH  (SCREEN_WIDTH),
        .HEIGHT (SCREEN_HEIGHT)
    ) u_pos (
        .clk     (clk),
        .rst     (rst),
        .advance (out_hs),
        .x       (pos_x),
        .y       (pos_y),
        .at_sof  (at_sof),
        .at_eol  (at_eol),
        .at_eof  (at_eof)
    );

    assign out_valid  = (state_q == SHIFT);
    assign out_data   = lane_buf_q[lane_q];
    assign out_sof    = out_valid && at_sof;
    assign out_eol    = out_valid && at_eol;
    assign frame_done = frame_done_q;

    always_comb begin
        out_hs       = out_valid && out_ready;
        last_hs      = out_hs && (lane_q == last_lane_q);
        in_ready     = !rst && ((state_q == EMPTY) || last_hs);
        in_acc       = in_valid && in_ready;
        state_d      = state_q;
        lane_d       = lane_q;
        last_lane_d  = last_lane_q;
        lane_buf_d   = lane_buf_q;
        frame_done_d = out_hs && at_eof;

        // A batch accepted alongside the last handshake starts at the post-advance column.
        x_start = pos_x;
        if (out_hs) begin
            x_start = at_eol ? '0 : pos_x + XW'(1);
        end
        rem = SCREEN_WIDTH - int'(x_start);

        if (in_acc) begin
            lane_buf_d  = in_rgb;
            lane_d      = '0;
            last_lane_d = (rem >= NUM_ENGINES) ? LW'(NUM_ENGINES - 1) : LW'(rem - 1);
            state_d     = SHIFT;
        end else if (last_hs) begin
            state_d = EMPTY;
        end else if (out_hs) begin
            lane_d = lane_q + LW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= EMPTY;
            lane_q       <= '0;
            last_lane_q  <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            lane_q       <= lane_d;
            last_lane_q  <= last_lane_d;
            frame_done_q <= frame_done_d;
        end
    end

    always_ff @(posedge clk) begin
        lane_buf_q <= lane_buf_d;
    end

endmodule
